// File: rtl/fill_seal_line_sequencer.sv
// Batch sequencer for the fill/seal packaging line: runs BATCH_SIZE units through
// fill, transfer, quality wait and seal, rejecting units not confirmed in time.
module fill_seal_line_sequencer #(
  parameter int unsigned FILL_CYCLES = 8,
  parameter int unsigned SEAL_CYCLES = 4,
  parameter int unsigned OK_TIMEOUT  = 16,
  parameter int unsigned BATCH_SIZE  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       product_ok,
  input  logic       abort,
  output logic       fill_en,
  output logic       seal_en,
  output logic       reject,
  output logic       done,
  output logic       busy,
  output logic [2:0] state,
  output logic [7:0] good_count,
  output logic [7:0] reject_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_XFER    = 3'd2,
    S_WAIT_OK = 3'd3,
    S_SEAL    = 3'd4,
    S_REJECT  = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  localparam logic [7:0] FILL_LOAD = 8'(FILL_CYCLES - 1);
  localparam logic [7:0] SEAL_LOAD = 8'(SEAL_CYCLES - 1);
  localparam logic [7:0] OK_LOAD   = 8'(OK_TIMEOUT - 1);
  localparam logic [7:0] BATCH_N   = 8'(BATCH_SIZE);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] unit_q, unit_d;
  logic [7:0] good_q, good_d;
  logic [7:0] rej_q, rej_d;
  logic [7:0] unit_inc;
  logic       fill_q, seal_q, reject_q, done_q, busy_q;

  assign unit_inc = unit_q + 8'd1;

  always_comb begin
    // NOTE: every signal gets a hold default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    timer_d = timer_q;
    unit_d  = unit_q;
    good_d  = good_q;
    rej_d   = rej_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d = S_FILL;
            timer_d = FILL_LOAD;
            unit_d  = 8'd0;
            good_d  = 8'd0;
            rej_d   = 8'd0;
          end
        end
        S_FILL: begin
          if (timer_q == 8'd0) state_d = S_XFER;
          else                 timer_d = timer_q - 8'd1;
        end
        S_XFER: begin
          state_d = S_WAIT_OK;
          timer_d = OK_LOAD;
        end
        S_WAIT_OK: begin
          // Confirmation wins over the timeout, so a late product_ok still seals.
          if (product_ok) begin
            state_d = S_SEAL;
            timer_d = SEAL_LOAD;
          end else if (timer_q == 8'd0) begin
            state_d = S_REJECT;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        S_SEAL: begin
          if (timer_q == 8'd0) begin
            good_d = good_q + 8'd1;
            unit_d = unit_inc;
            if (unit_inc == BATCH_N) begin
              state_d = S_DONE;
            end else begin
              state_d = S_FILL;
              timer_d = FILL_LOAD;
            end
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        S_REJECT: begin
          if (rej_q != 8'hFF) rej_d = rej_q + 8'd1;
          unit_d = unit_inc;
          if (unit_inc == BATCH_N) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FILL;
            timer_d = FILL_LOAD;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so they align with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= 8'd0;
      unit_q   <= 8'd0;
      good_q   <= 8'd0;
      rej_q    <= 8'd0;
      fill_q   <= 1'b0;
      seal_q   <= 1'b0;
      reject_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      timer_q  <= timer_d;
      unit_q   <= unit_d;
      good_q   <= good_d;
      rej_q    <= rej_d;
      fill_q   <= (state_d == S_FILL);
      seal_q   <= (state_d == S_SEAL);
      reject_q <= (state_d == S_REJECT);
      done_q   <= (state_d == S_DONE);
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign state        = state_q;
  assign fill_en      = fill_q;
  assign seal_en      = seal_q;
  assign reject       = reject_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign good_count   = good_q;
  assign reject_count = rej_q;

endmodule

// File: tb/tb_fill_seal_line_sequencer.sv
// Bench for fill_seal_line_sequencer: two instances (BATCH 2 and BATCH 1) share inputs
// and are compared cycle by cycle against a trace built from the unit-by-unit rules.
module tb_fill_seal_line_sequencer;

  localparam int F  = 4;
  localparam int S  = 3;
  localparam int T  = 5;
  localparam int BA = 2;
  localparam int BB = 1;
  localparam int OKN = 64;

  localparam logic [2:0] IDLE = 3'd0, FILL = 3'd1, XFER = 3'd2, WAIT = 3'd3,
                         SEAL = 3'd4, REJ = 3'd5, DONE = 3'd6;

  typedef logic [2:0] st_t;

  logic clk = 1'b0;
  logic rst_n, start, product_ok, abort;
  logic a_fill, a_seal, a_rej, a_done, a_busy;
  logic b_fill, b_seal, b_rej, b_done, b_busy;
  logic [2:0] a_state, b_state;
  logic [7:0] a_good, a_rejc, b_good, b_rejc;

  int vectors = 0;
  int miscompares = 0;
  bit ok_tab [OKN];

  always #5 clk = ~clk;

  fill_seal_line_sequencer #(.FILL_CYCLES(F), .SEAL_CYCLES(S), .OK_TIMEOUT(T), .BATCH_SIZE(BA)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .product_ok(product_ok), .abort(abort),
    .fill_en(a_fill), .seal_en(a_seal), .reject(a_rej), .done(a_done), .busy(a_busy),
    .state(a_state), .good_count(a_good), .reject_count(a_rejc));

  fill_seal_line_sequencer #(.FILL_CYCLES(F), .SEAL_CYCLES(S), .OK_TIMEOUT(T), .BATCH_SIZE(BB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .product_ok(product_ok), .abort(abort),
    .fill_en(b_fill), .seal_en(b_seal), .reject(b_rej), .done(b_done), .busy(b_busy),
    .state(b_state), .good_count(b_good), .reject_count(b_rejc));

  // Expected state per cycle after the start edge, unit by unit, using ok_tab[cycle].
  task automatic build_trace(input int batch, output st_t tr[$], output int good, output int rej);
    bit sealed;
    int idx;
    tr = {};
    good = 0;
    rej = 0;
    for (int u = 0; u < batch; u++) begin
      for (int i = 0; i < F; i++) tr.push_back(FILL);
      tr.push_back(XFER);
      sealed = 0;
      for (int k = 0; k < T; k++) begin
        idx = tr.size();
        tr.push_back(WAIT);
        if (idx < OKN && ok_tab[idx]) begin
          sealed = 1;
          break;
        end
      end
      if (sealed) begin
        for (int i = 0; i < S; i++) tr.push_back(SEAL);
        good++;
      end else begin
        tr.push_back(REJ);
        rej++;
      end
    end
    tr.push_back(DONE);
  endtask

  function automatic logic [7:0] exp_vec(input st_t st);
    return {st, st == FILL, st == SEAL, st == REJ, st == DONE, st != IDLE};
  endfunction

  // Starts a batch from IDLE and compares both instances every cycle against the traces.
  task automatic play_batch(input string name, output int done_at_a);
    st_t qa[$], qb[$];
    int ga, ra, gb, rb, ncyc;
    logic [7:0] ea, eb, oa, ob;
    build_trace(BA, qa, ga, ra);
    build_trace(BB, qb, gb, rb);
    ncyc = ((qa.size() > qb.size()) ? qa.size() : qb.size()) + 2;
    done_at_a = -1;
    abort = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < ncyc; t++) begin
      product_ok = (t < OKN) ? ok_tab[t] : 1'b0;
      ea = exp_vec((t < qa.size()) ? qa[t] : IDLE);
      eb = exp_vec((t < qb.size()) ? qb[t] : IDLE);
      oa = {a_state, a_fill, a_seal, a_rej, a_done, a_busy};
      ob = {b_state, b_fill, b_seal, b_rej, b_done, b_busy};
      if (a_done && done_at_a < 0) done_at_a = t;
      vectors += 2;
      if (oa !== ea) begin
        miscompares++;
        $display("FAIL %s dut_a cycle %0d {state,fill,seal,rej,done,busy} got %b want %b", name, t, oa, ea);
      end
      if (ob !== eb) begin
        miscompares++;
        $display("FAIL %s dut_b cycle %0d {state,fill,seal,rej,done,busy} got %b want %b", name, t, ob, eb);
      end
      @(posedge clk); #1;
    end
    product_ok = 1'b0;
    vectors += 2;
    if ({a_good, a_rejc} !== {8'(ga), 8'(ra)}) begin
      miscompares++;
      $display("FAIL %s dut_a counters good/rej got %0d/%0d want %0d/%0d", name, a_good, a_rejc, ga, ra);
    end
    if ({b_good, b_rejc} !== {8'(gb), 8'(rb)}) begin
      miscompares++;
      $display("FAIL %s dut_b counters good/rej got %0d/%0d want %0d/%0d", name, b_good, b_rejc, gb, rb);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; product_ok = 1'b0; abort = 1'b0;
    #12;
    vectors += 2;
    if ({a_state, a_fill, a_seal, a_rej, a_done, a_busy, a_good, a_rejc} !== 24'd0) begin
      miscompares++;
      $display("FAIL reset dut_a outputs got %h want 0", {a_state, a_fill, a_seal, a_rej, a_done, a_busy, a_good, a_rejc});
    end
    if ({b_state, b_fill, b_seal, b_rej, b_done, b_busy, b_good, b_rejc} !== 24'd0) begin
      miscompares++;
      $display("FAIL reset dut_b outputs got %h want 0", {b_state, b_fill, b_seal, b_rej, b_done, b_busy, b_good, b_rejc});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_all_ok();
    int d;
    for (int i = 0; i < OKN; i++) ok_tab[i] = 1'b1;
    play_batch("all_ok", d);
    vectors++;
    if (d !== 18) begin
      miscompares++;
      $display("FAIL all_ok done cycle got %0d want 18", d);
    end
  endtask

  task automatic test_timeout();
    int d;
    for (int i = 0; i < OKN; i++) ok_tab[i] = 1'b0;
    play_batch("timeout", d);
  endtask

  task automatic test_last_cycle_ok();
    int d;
    for (int i = 0; i < OKN; i++) ok_tab[i] = 1'b0;
    ok_tab[9] = 1'b1;  // 5th WAIT_OK cycle of unit 1
    play_batch("last_ok", d);
  endtask

  task automatic test_random();
    int d;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < OKN; i++) ok_tab[i] = ($urandom_range(0, 2) == 0);
      play_batch("random", d);
    end
  endtask

  task automatic test_abort();
    product_ok = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    vectors++;
    if (a_seal !== 1'b1) begin
      miscompares++;
      $display("FAIL abort pre seal_en got %b want 1", a_seal);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    vectors += 2;
    if ({a_state, a_seal, a_done, a_busy, a_good} !== 14'd0) begin
      miscompares++;
      $display("FAIL abort_seal dut_a {state,seal,done,busy,good} got %h want 0", {a_state, a_seal, a_done, a_busy, a_good});
    end
    if ({b_state, b_seal, b_done, b_busy, b_good} !== 14'd0) begin
      miscompares++;
      $display("FAIL abort_seal dut_b {state,seal,done,busy,good} got %h want 0", {b_state, b_seal, b_done, b_busy, b_good});
    end
    @(posedge clk); #1;
    vectors++;
    if (a_done !== 1'b0 || b_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_nodone got %b%b want 00", a_done, b_done);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if ({a_state, a_fill} !== {FILL, 1'b1}) begin
      miscompares++;
      $display("FAIL restart_fill got state %0d fill %b want 1 1", a_state, a_fill);
    end
    repeat (10) begin @(posedge clk); #1; end
    vectors++;
    if ({a_state, a_good, b_state, b_good} !== {FILL, 8'd1, IDLE, 8'd1}) begin
      miscompares++;
      $display("FAIL abort_pre2 got a %0d/%0d b %0d/%0d want 1/1 0/1", a_state, a_good, b_state, b_good);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    vectors++;
    if ({a_state, a_fill, a_good, b_good} !== {IDLE, 1'b0, 8'd1, 8'd1}) begin
      miscompares++;
      $display("FAIL abort_hold got a %0d fill %b good %0d b good %0d want 0 0 1 1", a_state, a_fill, a_good, b_good);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if ({a_good, b_good} !== 16'd0) begin
      miscompares++;
      $display("FAIL restart_clear got %0d %0d want 0 0", a_good, b_good);
    end
    repeat (25) begin @(posedge clk); #1; end
    product_ok = 1'b0;
    vectors++;
    if ({a_state, a_good, b_state, b_good} !== {IDLE, 8'd2, IDLE, 8'd1}) begin
      miscompares++;
      $display("FAIL abort_rerun got a %0d/%0d b %0d/%0d want 0/2 0/1", a_state, a_good, b_state, b_good);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    vectors++;
    if (a_fill !== 1'b1) begin
      miscompares++;
      $display("FAIL arst pre fill_en got %b want 1", a_fill);
    end
    rst_n = 1'b0;
    #1;
    vectors += 2;
    if ({a_state, a_fill, a_busy, a_good, a_rejc} !== 21'd0) begin
      miscompares++;
      $display("FAIL arst dut_a got %h want 0", {a_state, a_fill, a_busy, a_good, a_rejc});
    end
    if ({b_state, b_fill, b_busy, b_good, b_rejc} !== 21'd0) begin
      miscompares++;
      $display("FAIL arst dut_b got %h want 0", {b_state, b_fill, b_busy, b_good, b_rejc});
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({a_state, a_busy, a_fill, b_state, b_busy} !== 9'd0) begin
      miscompares++;
      $display("FAIL start_abort_idle got %b want 0", {a_state, a_busy, a_fill, b_state, b_busy});
    end
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_all_ok();
    test_timeout();
    test_last_cycle_ok();
    test_abort();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
